// File: rtl/decode_stage.sv
// Registered instruction-decode stage: valid/ready handshake on both sides, RUN/HALTED FSM and flush.
// Optional feature: define DECODE_PERF_EN to enable the 32-bit retireCount counter.
module decode_stage #(
  parameter int REG_AW = 4,
  parameter int IMM_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4+3*REG_AW-1:0] instr,
  input  logic                  inValid,
  output logic                  inReady,
  output logic                  outValid,
  input  logic                  outReady,
  input  logic                  flush,
  input  logic                  resume,
  output logic                  halted,
  output logic [1:0]            aluFunc,
  output logic [1:0]            shiftFunc,
  output logic [REG_AW-1:0]     regWriteAddr,
  output logic [REG_AW-1:0]     regX,
  output logic [REG_AW-1:0]     regY,
  output logic [IMM_W-1:0]      dOut,
  output logic                  jump,
  output logic                  neg,
  output logic                  zero,
  output logic                  compare,
  output logic                  stack,
  output logic                  memRead,
  output logic                  memWrite,
  output logic                  aluEnable,
  output logic                  regLoad,
  output logic                  constant,
  output logic                  halt,
  output logic                  shiftEnable,
  output logic [31:0]           retireCount
);

  localparam int FW    = 3 * REG_AW;
  localparam int IMM_L = 2 * REG_AW;

  typedef enum logic {RUN, HALTED} state_t;

  typedef struct packed {
    logic [1:0]        alu_func;
    logic [1:0]        shift_func;
    logic [REG_AW-1:0] wa;
    logic [REG_AW-1:0] rx;
    logic [REG_AW-1:0] ry;
    logic [IMM_W-1:0]  dout;
    logic jump, neg, zero, compare, stack, mem_read, mem_write;
    logic alu_enable, reg_load, constant, halt, shift_enable;
  } bundle_t;

  state_t  state;
  bundle_t bundle_q, dec;
  logic    out_valid_q;
  logic    accept;

  logic [3:0]        op;
  logic [FW-1:0]     f;
  logic [REG_AW-1:0] fa, fb, fc;
  logic [IMM_L-1:0]  imm, neg_imm;
  logic              s, sub;

  assign op      = instr[FW+3:FW];
  assign f       = instr[FW-1:0];
  assign fa      = f[FW-1 -: REG_AW];
  assign fb      = f[2*REG_AW-1 -: REG_AW];
  assign fc      = f[REG_AW-1:0];
  assign imm     = f[FW-1:REG_AW];
  assign neg_imm = -imm;
  assign s       = f[FW-1];
  assign sub     = f[FW-2];

  assign inReady = (state == RUN) && (!out_valid_q || outReady) && !flush;
  assign accept  = inValid && inReady;

  // NOTE: every field gets a default before the case, so no path leaves a latch behind.
  always_comb begin
    dec = '0;
    unique case (op)
      4'h0: dec.halt = 1'b1;
      4'h1, 4'h2, 4'h3, 4'h4: begin
        dec.alu_enable = 1'b1;
        dec.reg_load   = 1'b1;
        dec.alu_func   = (op == 4'h1) ? 2'b10 : (op == 4'h2) ? 2'b11 :
                         (op == 4'h3) ? 2'b00 : 2'b01;
        dec.wa = fa; dec.rx = fb; dec.ry = fc;
      end
      4'h5: begin
        dec.alu_enable = 1'b1;
        dec.reg_load   = 1'b1;
        dec.constant   = 1'b1;
        dec.alu_func   = s ? 2'b01 : 2'b00;
        dec.wa = fc; dec.rx = fc; dec.ry = fc;
        // Negation wraps within the immediate width before zero extension.
        dec.dout = IMM_W'(s ? neg_imm : imm);
      end
      4'h6: begin
        dec.compare    = 1'b1;
        dec.alu_enable = 1'b1;
        dec.alu_func   = s ? 2'b10 : 2'b01;
        dec.wa = fb; dec.rx = fb; dec.ry = fc;
      end
      4'h7: begin
        dec.reg_load = 1'b1;
        dec.wa = fb; dec.rx = fb; dec.ry = fc;
      end
      4'h8: begin
        dec.reg_load = 1'b1;
        dec.constant = 1'b1;
        dec.wa = fc; dec.rx = fc; dec.ry = fc;
        dec.dout = IMM_W'($signed(imm));
      end
      4'h9: begin
        dec.stack     = s;
        dec.mem_read  = sub;
        dec.mem_write = !sub;
        dec.reg_load  = sub;
        dec.wa = s ? fc : fb; dec.rx = s ? fc : fb; dec.ry = fc;
      end
      4'hA: begin
        dec.shift_enable = 1'b1;
        dec.shift_func   = f[FW-1:FW-2];
        dec.wa = fb; dec.rx = fb; dec.ry = fb;
        dec.dout = IMM_W'($signed(fc));
      end
      4'hB: begin
        dec.stack     = 1'b1;
        dec.mem_write = 1'b1;
        dec.wa = fb; dec.rx = fc; dec.ry = fc;
      end
      4'hC: begin
        dec.stack    = 1'b1;
        dec.mem_read = 1'b1;
        dec.reg_load = 1'b1;
        dec.wa = fc; dec.rx = fc; dec.ry = fc;
      end
      default: begin
        dec.jump     = 1'b1;
        dec.compare  = 1'b1;
        dec.neg      = (op == 4'hD);
        dec.zero     = (op == 4'hE);
        dec.wa = fc; dec.rx = fc; dec.ry = fc;
        dec.constant = s;
        dec.dout     = s ? f[IMM_W-1:0] : '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      if (accept) begin
        bundle_q    <= dec;
        out_valid_q <= 1'b1;
      end else if (flush || outReady) begin
        out_valid_q <= 1'b0;
      end

      if (state == HALTED) begin
        if (resume) state <= RUN;
      end else if (accept && op == 4'h0) begin
        state <= HALTED;
      end
    end
  end

  assign outValid     = out_valid_q;
  assign halted       = (state == HALTED);
  assign aluFunc      = bundle_q.alu_func;
  assign shiftFunc    = bundle_q.shift_func;
  assign regWriteAddr = bundle_q.wa;
  assign regX         = bundle_q.rx;
  assign regY         = bundle_q.ry;
  assign dOut         = bundle_q.dout;
  assign jump         = bundle_q.jump;
  assign neg          = bundle_q.neg;
  assign zero         = bundle_q.zero;
  assign compare      = bundle_q.compare;
  assign stack        = bundle_q.stack;
  assign memRead      = bundle_q.mem_read;
  assign memWrite     = bundle_q.mem_write;
  assign aluEnable    = bundle_q.alu_enable;
  assign regLoad      = bundle_q.reg_load;
  assign constant     = bundle_q.constant;
  assign halt         = bundle_q.halt;
  assign shiftEnable  = bundle_q.shift_enable;

`ifdef DECODE_PERF_EN
  logic [31:0] retire_q;

  // A flushed bundle is discarded, so it never counts as retired.
  always_ff @(posedge clk) begin
    if (!rst_n)                                retire_q <= '0;
    else if (out_valid_q && outReady && !flush) retire_q <= retire_q + 32'd1;
  end

  assign retireCount = retire_q;
`else
  assign retireCount = '0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage with hand-computed expected bundles.
// Retire-count expectations follow DECODE_PERF_EN when it is defined for the bench build.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] instr;
  logic        inValid, inReady, outValid, outReady, flush, resume, halted;
  logic [1:0]  aluFunc, shiftFunc;
  logic [3:0]  regWriteAddr, regX, regY;
  logic [9:0]  dOut;
  logic        jump, neg, zero, compare, stack, memRead, memWrite;
  logic        aluEnable, regLoad, constant, halt, shiftEnable;
  logic [31:0] retireCount;

  int vectors    = 0;
  int miscompares = 0;
  int exp_retire = 0;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .inValid(inValid), .inReady(inReady),
    .outValid(outValid), .outReady(outReady), .flush(flush), .resume(resume),
    .halted(halted), .aluFunc(aluFunc), .shiftFunc(shiftFunc),
    .regWriteAddr(regWriteAddr), .regX(regX), .regY(regY), .dOut(dOut),
    .jump(jump), .neg(neg), .zero(zero), .compare(compare), .stack(stack),
    .memRead(memRead), .memWrite(memWrite), .aluEnable(aluEnable),
    .regLoad(regLoad), .constant(constant), .halt(halt),
    .shiftEnable(shiftEnable), .retireCount(retireCount)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ret_exp();
`ifdef DECODE_PERF_EN
    return 32'(exp_retire);
`else
    return 32'd0;
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] w);
    instr = w; inValid = 1'b1; outReady = 1'b1;
    cyc();
    inValid = 1'b0;
  endtask

  task automatic drain();
    outReady = 1'b1; inValid = 1'b0;
    cyc();
    exp_retire++;
    vectors++;
    if (outValid !== 1'b0) begin
      miscompares++; $display("FAIL drain_valid: got %b expected 0", outValid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr = 16'h3123; inValid = 1'b1; outReady = 1'b1;
    flush = 1'b0; resume = 1'b0;
    cyc(); cyc();
    vectors++;
    if ({outValid, halted, aluEnable, regLoad, halt} !== 5'b0) begin
      miscompares++; $display("FAIL reset_flags: got %b expected 00000",
                              {outValid, halted, aluEnable, regLoad, halt});
    end
    vectors++;
    if ({regWriteAddr, regX, regY, dOut} !== 22'h0) begin
      miscompares++; $display("FAIL reset_fields: got %h expected 0",
                              {regWriteAddr, regX, regY, dOut});
    end
    vectors++;
    if (retireCount !== 32'd0) begin
      miscompares++; $display("FAIL reset_retire: got %0d expected 0", retireCount);
    end
    inValid = 1'b0; rst_n = 1'b1;
    cyc();
    vectors++;
    if ({inReady, outValid} !== 2'b10) begin
      miscompares++; $display("FAIL reset_ready: got %b expected 10", {inReady, outValid});
    end
  endtask

  task automatic test_alu();
    issue(16'h3123);
    vectors++;
    if ({outValid, aluEnable, regLoad, constant, aluFunc} !== 6'b111000) begin
      miscompares++; $display("FAIL add_ctrl: got %b expected 111000",
                              {outValid, aluEnable, regLoad, constant, aluFunc});
    end
    vectors++;
    if ({regWriteAddr, regX, regY} !== 12'h123) begin
      miscompares++; $display("FAIL add_addrs: got %h expected 123", {regWriteAddr, regX, regY});
    end
    drain();
  endtask

  task automatic test_addi();
    issue(16'h5F83);
    vectors++;
    if ({aluFunc, constant, regWriteAddr, regX, regY, dOut} !== {2'b01, 1'b1, 12'h333, 10'h008}) begin
      miscompares++; $display("FAIL addi_neg: got %h expected %h",
                              {aluFunc, constant, regWriteAddr, regX, regY, dOut},
                              {2'b01, 1'b1, 12'h333, 10'h008});
    end
    drain();
    issue(16'h5801);
    vectors++;
    if ({aluFunc, dOut} !== {2'b01, 10'h080}) begin
      miscompares++; $display("FAIL addi_wrap: got %h expected %h", {aluFunc, dOut}, {2'b01, 10'h080});
    end
    drain();
  endtask

  task automatic test_cpyc();
    issue(16'h8F85);
    vectors++;
    if ({regLoad, constant, aluEnable, regWriteAddr, dOut} !== {3'b110, 4'h5, 10'h3F8}) begin
      miscompares++; $display("FAIL cpyc: got %h expected %h",
                              {regLoad, constant, aluEnable, regWriteAddr, dOut},
                              {3'b110, 4'h5, 10'h3F8});
    end
    drain();
  endtask

  task automatic test_jump();
    issue(16'hF8A5);
    vectors++;
    if ({jump, compare, constant, neg, zero, regWriteAddr, dOut} !== {5'b11100, 4'h5, 10'h0A5}) begin
      miscompares++; $display("FAIL jmp_const: got %h expected %h",
                              {jump, compare, constant, neg, zero, regWriteAddr, dOut},
                              {5'b11100, 4'h5, 10'h0A5});
    end
    drain();
    issue(16'hF0A5);
    vectors++;
    if ({jump, constant, dOut} !== {2'b10, 10'h000}) begin
      miscompares++; $display("FAIL jmp_reg: got %h expected %h", {jump, constant, dOut}, {2'b10, 10'h000});
    end
    drain();
    issue(16'hD0A5);
    vectors++;
    if ({jump, neg, zero} !== 3'b110) begin
      miscompares++; $display("FAIL jmpl_flags: got %b expected 110", {jump, neg, zero});
    end
    drain();
  endtask

  task automatic test_shift_mem();
    issue(16'hA9CE);
    vectors++;
    if ({shiftEnable, shiftFunc, regX, dOut} !== {1'b1, 2'b10, 4'hC, 10'h3FE}) begin
      miscompares++; $display("FAIL shift: got %h expected %h",
                              {shiftEnable, shiftFunc, regX, dOut}, {1'b1, 2'b10, 4'hC, 10'h3FE});
    end
    drain();
    issue(16'h9C12);
    vectors++;
    if ({stack, memRead, memWrite, regLoad, regWriteAddr, regX, regY} !== {4'b1101, 12'h222}) begin
      miscompares++; $display("FAIL mem_load: got %h expected %h",
                              {stack, memRead, memWrite, regLoad, regWriteAddr, regX, regY},
                              {4'b1101, 12'h222});
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3] = '{16'h1123, 16'h2456, 16'h4789};
    logic [5:0]  exp   [3] = '{{2'b10, 4'h1}, {2'b11, 4'h4}, {2'b01, 4'h7}};
    outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      instr = words[i]; inValid = 1'b1;
      cyc();
      if (i > 0) exp_retire++;
      vectors++;
      if ({outValid, inReady, aluFunc, regWriteAddr} !== {2'b11, exp[i]}) begin
        miscompares++; $display("FAIL b2b_%0d: got %h expected %h", i,
                                {outValid, inReady, aluFunc, regWriteAddr}, {2'b11, exp[i]});
      end
    end
    drain();
  endtask

  task automatic test_stall();
    instr = 16'h3456; inValid = 1'b1; outReady = 1'b0;
    cyc();
    instr = 16'h3789;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({outValid, inReady, regWriteAddr} !== {2'b10, 4'h4}) begin
        miscompares++; $display("FAIL stall_%0d: got %h expected %h", i,
                                {outValid, inReady, regWriteAddr}, {2'b10, 4'h4});
      end
      cyc();
    end
    outReady = 1'b1;
    cyc();
    exp_retire++;
    vectors++;
    if ({outValid, regWriteAddr, retireCount} !== {1'b1, 4'h7, ret_exp()}) begin
      miscompares++; $display("FAIL stall_release: got %h expected %h",
                              {outValid, regWriteAddr, retireCount}, {1'b1, 4'h7, ret_exp()});
    end
    drain();
  endtask

  task automatic test_halt();
    issue(16'h0000);
    vectors++;
    if ({halted, halt, outValid, inReady} !== 4'b1110) begin
      miscompares++; $display("FAIL halt_enter: got %b expected 1110", {halted, halt, outValid, inReady});
    end
    instr = 16'h3123; inValid = 1'b1; outReady = 1'b1;
    cyc();
    exp_retire++;
    vectors++;
    if ({halted, outValid, inReady} !== 3'b100) begin
      miscompares++; $display("FAIL halt_hold: got %b expected 100", {halted, outValid, inReady});
    end
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1;
    vectors++;
    if ({halted, inReady} !== 2'b10) begin
      miscompares++; $display("FAIL halt_flush: got %b expected 10", {halted, inReady});
    end
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    #1;
    vectors++;
    if ({halted, inReady, outValid} !== 3'b010) begin
      miscompares++; $display("FAIL resume: got %b expected 010", {halted, inReady, outValid});
    end
    cyc();
    vectors++;
    if ({outValid, regWriteAddr} !== {1'b1, 4'h1}) begin
      miscompares++; $display("FAIL resume_accept: got %h expected %h", {outValid, regWriteAddr}, {1'b1, 4'h1});
    end
    drain();
  endtask

  task automatic test_flush();
    instr = 16'h3456; inValid = 1'b1; outReady = 1'b0;
    cyc();
    instr = 16'h3789; flush = 1'b1;
    #1;
    vectors++;
    if ({outValid, inReady} !== 2'b10) begin
      miscompares++; $display("FAIL flush_block: got %b expected 10", {outValid, inReady});
    end
    cyc();
    flush = 1'b0; inValid = 1'b0;
    #1;
    vectors++;
    if ({outValid, retireCount} !== {1'b0, ret_exp()}) begin
      miscompares++; $display("FAIL flush_clear: got %h expected %h", {outValid, retireCount}, {1'b0, ret_exp()});
    end
    outReady = 1'b1;
    cyc();
    vectors++;
    if ({outValid, retireCount} !== {1'b0, ret_exp()}) begin
      miscompares++; $display("FAIL flush_nocount: got %h expected %h", {outValid, retireCount}, {1'b0, ret_exp()});
    end
  endtask

  task automatic test_reset_midflight();
    instr = 16'h3456; inValid = 1'b1; outReady = 1'b0;
    cyc();
    rst_n = 1'b0; resume = 1'b1; flush = 1'b1;
    cyc();
    rst_n = 1'b1; resume = 1'b0; flush = 1'b0; inValid = 1'b0;
    exp_retire = 0;
    #1;
    vectors++;
    if ({outValid, halted, regWriteAddr, retireCount} !== {2'b00, 4'h0, 32'd0}) begin
      miscompares++; $display("FAIL reset_mid: got %h expected 0", {outValid, halted, regWriteAddr, retireCount});
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_addi();
    test_cpyc();
    test_jump();
    test_shift_mem();
    test_back_to_back();
    test_stall();
    test_halt();
    test_flush();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage between the instruction fetch buffer and the execute stage. It converts one instruction word per accepted handshake into the execute control bundle one cycle later. It adds valid/ready flow control on both sides, a halt/resume state machine, and a pipeline flush. Field widths are generalised through the register-address width.

## Interface

Parameters:
- REG_AW, 4: register address width; instruction width IW = 4 + 3*REG_AW.
- IMM_W, 10: width of `dOut` immediate; must satisfy 2*REG_AW ≤ IMM_W < 3*REG_AW.

Ports (reset is synchronous, active-low, single clock `clk`):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- instr  in  IW  {opcode[3:0], fA[REG_AW], fB[REG_AW], fC[REG_AW]}; F = {fA,fB,fC}
- inValid  in  1  upstream word valid
- inReady  out  1  stage can accept
- outValid  out  1  control bundle valid
- outReady  in  1  execute consumes bundle
- flush  in  1  discard held bundle (branch taken)
- resume  in  1  leave HALTED
- halted  out  1  state == HALTED
- aluFunc, shiftFunc  out  2 each
- regWriteAddr, regX, regY  out  REG_AW each
- dOut  out  IMM_W  immediate
- jump, neg, zero, compare, stack, memRead, memWrite, aluEnable, regLoad, constant, halt, shiftEnable  out  1 each
- retireCount  out  32  output handshakes (see Configuration)

## Operation

- Accept = inValid & inReady; inReady = (state==RUN) & (!outValid | outReady) & !flush.
- On accept, decode `instr` into the output register and set outValid. When outValid & outReady with no accept, clear outValid. Outputs stay stable while outValid & !outReady.
- Imm = F[3*REG_AW-1:REG_AW] (2*REG_AW bits); s = F MSB.
- Decode map (unlisted controls = 0, addresses = 0):
  - 0 halt: halt=1.
  - 1/2/3/4 and/or/add/sub: aluEnable=1, regLoad=1, aluFunc=10/11/00/01, regWriteAddr=fA, regX=fB, regY=fC.
  - 5 addi: aluEnable=1, regLoad=1, constant=1, all addrs=fC. aluFunc=s?01:00. dOut = zero-extend(s ? -Imm : Imm).
  - 6 compare: compare=1, aluEnable=1, aluFunc=s?10:01, regWriteAddr=regX=fB, regY=fC.
  - 7 copy: regLoad=1, regWriteAddr=regX=fB, regY=fC.
  - 8 cpyc: regLoad=1, constant=1, addrs=fC, dOut = sign-extend(Imm).
  - 9 mem: stack=s, memRead=F[MSB-1], memWrite=!F[MSB-1], regLoad=F[MSB-1], regWriteAddr=regX = s?fC:fB, regY=fC.
  - A shift: shiftEnable=1, shiftFunc=F[MSB:MSB-1], addrs=fB, dOut = sign-extend(fC).
  - B push: stack=1, memWrite=1, regWriteAddr=fB, regX=regY=fC.
  - C pop: stack=1, memRead=1, regLoad=1, addrs=fC.
  - D/E/F jmpl/jmpe/jmp: jump=1, compare=1, neg=(D), zero=(E), addrs=fC. If s: constant=1 and dOut=F[IMM_W-1:0]; otherwise dOut=0.
- FSM: states RUN and HALTED.
  - RUN→HALTED on accepting opcode 0.
  - HALTED→RUN on resume. The first accept can occur in the cycle after resume.
  - The halt bundle itself is still presented and must be consumed.
- Flush clears outValid on the next edge and blocks accept that cycle. A HALTED state is unaffected by flush.
- Reset: outValid=0, state=RUN, all control outputs and dOut 0, retireCount=0.

## Timing

- Latency 1 cycle, accept to outValid. Throughput 1 per cycle with outReady held high.
- inReady is combinational from outValid, outReady, flush and state. There is no combinational path from instr to outputs.
- Simultaneous accept and output handshake: the new bundle replaces the old one and outValid stays 1.
- rst_n low mid-transfer: the held bundle is discarded; reset has priority over flush, resume and accept.
- Negation in addi is modulo 2^(2*REG_AW): Imm=0x80 yields dOut=0x080.

## Configuration

- DECODE_PERF_EN defined: retireCount increments on each outValid & outReady and wraps at 2^32. Flushed bundles are not counted.
- Undefined: retireCount is tied to 0 and no counter logic is present.

## Test plan

- 0x3123, outReady=1 → next cycle: aluFunc=00, regWriteAddr=1, regX=2, regY=3, regLoad=1, aluEnable=1, outValid=1.
- addi 0x5F83 → aluFunc=01, constant=1, addrs=3, dOut=0x008. cpyc 0x8F85 → dOut=0x3F8, regWriteAddr=5.
- Jump 0xF8A5 → jump=1, compare=1, constant=1, dOut=0x0A5. Jump 0xF0A5 → constant=0, dOut=0.
- outReady=0 for 3 cycles with inValid=1 → bundle stable, inReady=0. Release → 1 retire, then next instruction accepted.
- Opcode 0 accepted → halted=1 and inReady=0 until a resume pulse. resume → RUN, accept on following cycle.
- flush while outValid=1, outReady=0 → outValid=0 next cycle. With DECODE_PERF_EN, retireCount unchanged.
